clken_gen: RTL and testbench
============================

# clken_gen

Multi-channel programmable clock-enable generator for the game's timing subsystem. From the 50 MHz master clock it produces NCH independent single-cycle tick strobes and matching square waves, for example the 25 MHz pixel enable, the seven-segment scan rate and the bird/pipe physics update rate. Each channel's divisor is reprogrammable at runtime, so game speed can change without restarting the other channels. All downstream logic stays on clk and uses the ticks as clock enables; the square waves are for observation and LED/debug only.

## Interface
- NCH, 4, number of channels (1..16)
- DIV_W, 16, divisor width in bits
- DEFAULT_DIV, 1, divisor loaded into every channel at reset (period = DEFAULT_DIV+1)
- clk  in  1  master clock, 50 MHz
- clr  in  1  asynchronous active-high reset
- run  in  1  global enable; 0 freezes all counters
- restart  in  1  synchronous phase realign of all channels
- wr_en  in  1  divisor write strobe
- wr_ch  in  4  channel index for write/readback
- wr_div  in  DIV_W  new divisor value
- wr_err  out  1  one-cycle pulse: write to wr_ch >= NCH (ignored)
- rd_div  out  DIV_W  active divisor of channel wr_ch, registered
- tick  out  NCH  per-channel one-cycle enable strobe
- sqw  out  NCH  per-channel square wave, toggles on each tick

## Operation
- Per channel: cnt (DIV_W bits), div_act, div_pend, pend flag.
- Reset (clr=1): cnt=0, div_act=div_pend=DEFAULT_DIV, pend=0, tick=0, sqw=0, wr_err=0, rd_div=DEFAULT_DIV.
- Boundary: the clk edge where run=1 and cnt==div_act. At a boundary: cnt<=0, tick<=1, sqw toggles, and div_act<=div_pend if pend (pend cleared).
- Otherwise, with run=1: cnt<=cnt+1 and tick<=0.
- With run=0: cnt, sqw and div_act hold and tick<=0. Writes are still accepted.
- Write (wr_en=1, wr_ch<NCH): div_pend<=wr_div and pend<=1. The new divisor never truncates or stretches the period in progress.
- Write on the same edge as that channel's boundary: wr_div becomes div_act at that boundary, so the next period already uses the new divisor. pend ends 0.
- Two writes to one channel before a boundary: the last one wins.
- Write with wr_ch>=NCH: no state change; wr_err=1 for one cycle.
- restart=1 (priority over run and boundary): all cnt<=0, sqw<=0, tick<=0, pending divisors adopted immediately, pend cleared. A coincident write is adopted as well.
- rd_div <= div_act[wr_ch] each edge. It reads 0 when wr_ch>=NCH.
- div=0: tick is high every cycle and sqw toggles every cycle.
- Counter arithmetic is unsigned DIV_W bits. cnt never exceeds div_act, so no wrap-around is possible.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Tick period = div_act+1 cycles. sqw period = 2·(div_act+1) cycles with 50% duty.
- After clr deasserts with run=1 and div D: the first tick is registered at edge D+1, then at every further D+1 edges.
- run 1→0→1: the phase resumes exactly where it stopped, with no lost or extra tick.
- Write latency: effective at the next boundary of that channel. If the write is coincident with a boundary, the new period starts immediately.
- clr mid-period: everything returns to reset values asynchronously. Pending writes are discarded.
- wr_err and rd_div take effect 1 cycle after the triggering edge.

## Test plan
- Reset default: clr released, run=1, DEFAULT_DIV=1. Expect tick[0] high every 2nd cycle, first high after edge 2; sqw[0] period 4.
- Reprogram mid-period: ch1 div=9, write 3 at cnt=4. Expect the current period still 10 cycles, then 4-cycle periods; rd_div reads 3 only after that boundary.
- Coincident write: write div=5 to ch2 on its boundary edge. Expect the next tick 6 cycles later, then every 6.
- Freeze: run low for 7 cycles at cnt=2 (div=4). Expect no ticks while frozen and the next tick 3 cycles after run returns.
- restart and invalid write: restart with ch0..3 at mixed phases and a pending write on ch3. Expect all cnt=0 and sqw=0, aligned ticks, and ch3 using the new divisor. A write to wr_ch=7 with NCH=4 gives a single wr_err pulse and no state change.
- Async reset mid-operation: assert clr between edges. Expect outputs to clear immediately and pending writes to be lost.

Source files
------------

// File: rtl/clken_gen.sv
// Multi-channel programmable clock-enable generator: per-channel tick strobes and
// square waves with runtime-reprogrammable divisors applied at period boundaries.
module clken_gen #(
    parameter int NCH         = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             restart,
    input  logic             wr_en,
    input  logic [3:0]       wr_ch,
    input  logic [DIV_W-1:0] wr_div,
    output logic             wr_err,
    output logic [DIV_W-1:0] rd_div,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sqw
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [4:0]       NCH_W5   = 5'(NCH);

    logic [DIV_W-1:0] cnt_r      [NCH];
    logic [DIV_W-1:0] cnt_s      [NCH];
    logic [DIV_W-1:0] act_r      [NCH];
    logic [DIV_W-1:0] act_s      [NCH];
    logic [DIV_W-1:0] pend_div_r [NCH];
    logic [DIV_W-1:0] pend_div_s [NCH];
    logic [DIV_W-1:0] adopt_s    [NCH];
    logic [NCH-1:0]   pend_r;
    logic [NCH-1:0]   pend_s;
    logic [NCH-1:0]   tick_r;
    logic [NCH-1:0]   tick_s;
    logic [NCH-1:0]   sqw_r;
    logic [NCH-1:0]   sqw_s;
    logic [NCH-1:0]   hit_s;
    logic [NCH-1:0]   bnd_s;
    logic             wr_ok_s;
    logic             wr_err_s;
    logic             wr_err_r;
    logic [DIV_W-1:0] rd_s;
    logic [DIV_W-1:0] rd_div_r;

    // Next-state computation for all channels plus write decode and readback mux.
    always_comb begin
        wr_ok_s  = wr_en & ({1'b0, wr_ch} < NCH_W5);
        wr_err_s = wr_en & ~({1'b0, wr_ch} < NCH_W5);
        rd_s     = DIV_ZERO;
        for (int i = 0; i < NCH; i++) begin
            rd_s          = ({1'b0, wr_ch} == 5'(i)) ? act_r[i] : rd_s;
            hit_s[i]      = wr_ok_s & (wr_ch == 4'(i));
            bnd_s[i]      = run & (cnt_r[i] == act_r[i]);
            // A coincident write overrides any older pending divisor.
            adopt_s[i]    = hit_s[i] ? wr_div : (pend_r[i] ? pend_div_r[i] : act_r[i]);
            cnt_s[i]      = cnt_r[i];
            act_s[i]      = act_r[i];
            pend_div_s[i] = hit_s[i] ? wr_div : pend_div_r[i];
            pend_s[i]     = pend_r[i];
            tick_s[i]     = 1'b0;
            sqw_s[i]      = sqw_r[i];
            if (restart) begin
                cnt_s[i]  = DIV_ZERO;
                sqw_s[i]  = 1'b0;
                act_s[i]  = adopt_s[i];
                pend_s[i] = 1'b0;
            end else if (bnd_s[i]) begin
                cnt_s[i]  = DIV_ZERO;
                tick_s[i] = 1'b1;
                sqw_s[i]  = ~sqw_r[i];
                act_s[i]  = adopt_s[i];
                pend_s[i] = 1'b0;
            end else if (run) begin
                cnt_s[i]  = cnt_r[i] + DIV_ONE;
                pend_s[i] = pend_r[i] | hit_s[i];
            end else begin
                pend_s[i] = pend_r[i] | hit_s[i];
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]      <= DIV_ZERO;
                act_r[i]      <= DIV_RST;
                pend_div_r[i] <= DIV_RST;
            end
            pend_r   <= {NCH{1'b0}};
            tick_r   <= {NCH{1'b0}};
            sqw_r    <= {NCH{1'b0}};
            wr_err_r <= 1'b0;
            rd_div_r <= DIV_RST;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]      <= cnt_s[i];
                act_r[i]      <= act_s[i];
                pend_div_r[i] <= pend_div_s[i];
            end
            pend_r   <= pend_s;
            tick_r   <= tick_s;
            sqw_r    <= sqw_s;
            wr_err_r <= wr_err_s;
            rd_div_r <= rd_s;
        end
    end

    assign tick   = tick_r;
    assign sqw    = sqw_r;
    assign wr_err = wr_err_r;
    assign rd_div = rd_div_r;

endmodule

// File: tb/tb_clken_gen.sv
// Randomized self-checking bench for clken_gen against a countdown-based reference model.
module tb_clken_gen;
    localparam int NCH = 4;
    localparam int DIV_W = 16;
    localparam int DEFAULT_DIV = 1;

    logic             clk = 1'b0;
    logic             clr, run, restart, wr_en;
    logic [3:0]       wr_ch;
    logic [DIV_W-1:0] wr_div;
    logic             wr_err;
    logic [DIV_W-1:0] rd_div;
    logic [NCH-1:0]   tick, sqw;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: edges left until the next boundary, active and pending divisor (-1 = none).
    int m_left [NCH];
    int m_act  [NCH];
    int m_pend [NCH];
    bit m_tick [NCH];
    bit m_sqw  [NCH];
    int m_err;
    int m_rd;

    clken_gen #(.NCH(NCH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk(clk), .clr(clr), .run(run), .restart(restart), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .wr_err(wr_err), .rd_div(rd_div),
        .tick(tick), .sqw(sqw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_act[i]  = DEFAULT_DIV;
            m_left[i] = DEFAULT_DIV + 1;
            m_pend[i] = -1;
            m_tick[i] = 1'b0;
            m_sqw[i]  = 1'b0;
        end
        m_err = 0;
        m_rd  = DEFAULT_DIV;
    endtask

    task automatic model_edge();
        bit ok;
        ok    = (int'(wr_ch) < NCH);
        m_err = (wr_en && !ok) ? 1 : 0;
        m_rd  = ok ? m_act[wr_ch] : 0;
        for (int i = 0; i < NCH; i++) begin
            bit hit;
            hit = wr_en && ok && (int'(wr_ch) == i);
            if (restart) begin
                if (hit) m_pend[i] = int'(wr_div);
                if (m_pend[i] >= 0) m_act[i] = m_pend[i];
                m_pend[i] = -1;
                m_left[i] = m_act[i] + 1;
                m_sqw[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end else if (run && m_left[i] == 1) begin
                if (hit) m_pend[i] = int'(wr_div);
                if (m_pend[i] >= 0) m_act[i] = m_pend[i];
                m_pend[i] = -1;
                m_left[i] = m_act[i] + 1;
                m_sqw[i]  = ~m_sqw[i];
                m_tick[i] = 1'b1;
            end else begin
                if (run) m_left[i]--;
                if (hit) m_pend[i] = int'(wr_div);
                m_tick[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NCH-1:0] et, es;
        for (int i = 0; i < NCH; i++) begin
            et[i] = m_tick[i];
            es[i] = m_sqw[i];
        end
        chk("tick", 32'(tick), 32'(et));
        chk("sqw", 32'(sqw), 32'(es));
        chk("wr_err", 32'(wr_err), 32'(m_err));
        chk("rd_div", 32'(rd_div), 32'(m_rd));
    endtask

    // One clock: model sees the inputs present at the edge, then outputs are checked.
    task automatic step();
        @(posedge clk);
        if (clr) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic wr(input int ch, input int d);
        wr_en  = 1'b1;
        wr_ch  = 4'(ch);
        wr_div = DIV_W'(d);
        step();
        wr_en  = 1'b0;
    endtask

    initial begin
        clr = 1'b1; run = 1'b1; restart = 1'b0; wr_en = 1'b0;
        wr_ch = 4'd0; wr_div = '0;
        model_reset();
        #13;
        compare_all();
        clr = 1'b0;
        // Default divisor: tick every 2nd cycle, first at edge 2.
        step();
        chk("first_edge_quiet", 32'(tick[0]), 32'd0);
        step();
        chk("first_tick_edge2", 32'(tick[0]), 32'd1);
        for (int k = 0; k < 8; k++) step();

        // Reprogram ch1 to 9, then to 3 mid-period; ch2 coincident-boundary write.
        wr(1, 9);
        for (int k = 0; k < 6; k++) step();
        wr(1, 3);
        wr_ch = 4'd1;
        for (int k = 0; k < 30; k++) step();
        wr(2, 5);
        for (int k = 0; k < 30; k++) step();

        // Freeze for 7 cycles.
        wr(0, 4);
        for (int k = 0; k < 9; k++) step();
        run = 1'b0;
        for (int k = 0; k < 7; k++) step();
        run = 1'b1;
        for (int k = 0; k < 12; k++) step();

        // Restart with a pending write on ch3, then an invalid channel write.
        wr(3, 7);
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_sqw", 32'(sqw), 32'd0);
        for (int k = 0; k < 20; k++) step();
        wr(7, 2);
        chk("bad_wr_err", 32'(wr_err), 32'd1);
        step();
        chk("bad_wr_err_once", 32'(wr_err), 32'd0);

        // Asynchronous clear between edges discards a pending write.
        wr(2, 11);
        step(); step(); step();
        #2 clr = 1'b1;
        #1;
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_sqw", 32'(sqw), 32'd0);
        chk("async_rd", 32'(rd_div), 32'(DEFAULT_DIV));
        model_reset();
        step();
        #3 clr = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            run     = ($urandom_range(9, 0) != 0);
            restart = ($urandom_range(49, 0) == 0);
            wr_en   = ($urandom_range(6, 0) == 0);
            wr_ch   = 4'($urandom_range(7, 0));
            wr_div  = DIV_W'($urandom_range(12, 0));
            step();
        end
        run = 1'b1; restart = 1'b0; wr_en = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
